aes_gcm_ctr_stage2: RTL and testbench
=====================================

// Module: aes_gcm_ctr_stage2
// PURPOSE
//  - Second stage of the AES-GCM pipeline. Sits directly downstream of the phase/sequencing
//    stage (stage 1).
//  - Consumes stage 1's per-block phase code, IV, AAD, text and instance size.
//  - Produces, one cycle later: the GCM counter blocks for the AES core, and the classified
//    AAD/text blocks for GHASH.
//  - At end of instance, emits a tag request carrying J0 and the len(A)||len(C) block.
// PARAMETERS
//  CTR_W            32   width of the inc32 field (low bits of counter block); upper 128-CTR_W bits never change
//  MAX_TEXT_BLOCKS  781  max text blocks per instance (100000-bit frame / 128); exceeding it raises o_err
// PORTS
//  clk               in   1    rising-edge clock
//  rst_n             in   1    synchronous active-low reset
//  i_phase           in   3    [0:2] stage-1 phase: 100 invalid, 010 AAD, 000 first text, 001 text, 011 last text, 111 first-and-last text
//  i_new_instance    in   1    first block of a new instance (coincides with block 0's phase)
//  i_iv              in   96   [0:95] IV, sampled only when i_new_instance=1
//  i_aad             in   128  [0:127] AAD block
//  i_plain_text      in   128  [0:127] plaintext block
//  i_instance_size   in   128  [0:127] {len(A) bits [0:63], len(C) bits [64:127]}, sampled with i_new_instance
//  o_aad_valid       out  1    o_aad carries an AAD block for GHASH
//  o_aad             out  128  registered AAD block
//  o_text_valid      out  1    o_text/o_ctr_block carry a text block and its counter
//  o_text_first      out  1    first text block of instance (qualifies o_text_valid)
//  o_text_last       out  1    last text block of instance (qualifies o_text_valid)
//  o_text            out  128  registered plaintext block
//  o_ctr_block       out  128  counter block to encrypt for o_text
//  o_tag_req         out  1    one-cycle pulse: final tag computation request
//  o_tag_ctr         out  128  J0 = IV||{CTR_W-1 zeros,1}, held from instance start
//  o_len_block       out  128  latched i_instance_size, held from instance start
//  o_err             out  1    one-cycle pulse on sequencing violation or block overflow
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - All outputs and registers go to 0; state=IDLE; tag_pending=0.
//    - Applies mid-instance too: the instance is dropped and no tag_req is issued.
//  - Latency: every valid/data output is registered, 1 cycle after the input block.
//    o_tag_req is 1 cycle after the o_text_last cycle.
//  - FSM states: IDLE, AAD, TEXT. Transitions are evaluated on i_phase when i_phase != 100.
//    - i_new_instance=1 (highest priority, any state):
//      - Latch J0 = {i_iv, CTR_W'd1} and o_len_block = i_instance_size.
//      - Reset text count. Any in-progress instance is abandoned silently: no tag, no err.
//      - Then process the block per its phase as below.
//    - 010 (IDLE/AAD/new): o_aad_valid=1; state->AAD.
//    - 000 (AAD/new): ctr = J0+1 (J0 taken from i_iv if new this cycle); o_text_valid=1,
//      o_text_first=1; state->TEXT.
//    - 001 (TEXT): ctr = inc32(ctr); o_text_valid=1; state stays TEXT.
//    - 011 (TEXT): ctr = inc32(ctr); o_text_valid=1, o_text_last=1; tag_pending=1; state->IDLE.
//    - 111 (AAD/new): ctr = J0+1; o_text_valid=o_text_first=o_text_last=1; tag_pending=1; state->IDLE.
//    - 100: no valid outputs; state, ctr and latched values hold.
//    - Any other phase/state combination is a violation:
//      - Examples: 001/011 in IDLE or AAD; 000/111 in TEXT without i_new_instance; 010 in TEXT.
//      - Response: o_err=1 for 1 cycle, block dropped (no valid), state->IDLE, tag_pending=0.
//  - inc32: low CTR_W bits += 1 mod 2^CTR_W; upper bits unchanged. 0xFFFFFFFF wraps to 0x00000000.
//  - Overflow: text count > MAX_TEXT_BLOCKS -> o_err pulse, block dropped, state->IDLE.
//  - Tag: cycle after tag_pending is set, o_tag_req=1 for exactly 1 cycle; tag_pending clears.
//    - o_tag_ctr/o_len_block remain valid that cycle even if i_new_instance re-latches them
//      (tag uses the pre-update copy).
//  - Data outputs o_aad/o_text/o_ctr_block are don't-care when their valid is 0. They still
//    reset to 0.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0; after release with
//    phase=100, no valid and no err.
//  - Basic instance: IV=0xCAFEBABEFACEDBADDECAF888, size={128,384}.
//    Sequence 010(new), 000, 001, 011 -> 1 aad_valid, then 3 text_valid.
//    - ctr low words: 0x00000002, 0x00000003, 0x00000004.
//    - last on 3rd text block; tag_req next cycle with tag_ctr = IV||0x00000001 and
//      len_block = {64'd128, 64'd384}.
//  - Single block: 111 with new_instance, size={0,128} -> text_first=text_last=1,
//    ctr=IV||0x00000002; tag_req 1 cycle later.
//  - Wrap: force ctr low word to 0xFFFFFFFE via IV||... stimulus, two 001 blocks ->
//    low words 0xFFFFFFFF then 0x00000000; upper 96 bits unchanged.
//  - Violations: 001 while IDLE -> o_err=1 for 1 cycle, no text_valid. Back-to-back
//    instances (new on cycle after 011) -> tag_req uses the first IV, second instance
//    starts with its own J0+1.
//  - Reset mid-instance after 2 text blocks -> no tag_req. A following 000(new) restarts
//    at ctr low word 0x00000002.

Source files
------------

// File: rtl/aes_gcm_ctr_stage2_if.sv
// Block interface between the stage-1 sequencer and the counter/classify stage.
// master = stage-1 side (drives i_*), slave = this stage (drives o_*).
interface aes_gcm_ctr_stage2_if;
  logic [2:0]   i_phase;
  logic         i_new_instance;
  logic [95:0]  i_iv;
  logic [127:0] i_aad;
  logic [127:0] i_plain_text;
  logic [127:0] i_instance_size;

  logic         o_aad_valid;
  logic [127:0] o_aad;
  logic         o_text_valid;
  logic         o_text_first;
  logic         o_text_last;
  logic [127:0] o_text;
  logic [127:0] o_ctr_block;
  logic         o_tag_req;
  logic [127:0] o_tag_ctr;
  logic [127:0] o_len_block;
  logic         o_err;

  modport master (
    output i_phase, i_new_instance, i_iv, i_aad, i_plain_text, i_instance_size,
    input  o_aad_valid, o_aad, o_text_valid, o_text_first, o_text_last, o_text,
           o_ctr_block, o_tag_req, o_tag_ctr, o_len_block, o_err
  );

  modport slave (
    input  i_phase, i_new_instance, i_iv, i_aad, i_plain_text, i_instance_size,
    output o_aad_valid, o_aad, o_text_valid, o_text_first, o_text_last, o_text,
           o_ctr_block, o_tag_req, o_tag_ctr, o_len_block, o_err
  );
endinterface

// File: rtl/aes_gcm_ctr_stage2.sv
// AES-GCM stage 2: classifies AAD/text blocks, generates counter blocks and the end-of-instance tag request.
//
// state | meaning
// IDLE  | no instance open; only AAD or a new instance is accepted
// AAD   | AAD seen; AAD or the first text block may follow
// TEXT  | text in progress; continuation or last text block expected
module aes_gcm_ctr_stage2 #(
  parameter int CTR_W           = 32,
  parameter int MAX_TEXT_BLOCKS = 781
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_gcm_ctr_stage2_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_TEXT_BLOCKS + 2);

  localparam logic [2:0] PH_INV   = 3'b100;
  localparam logic [2:0] PH_AAD   = 3'b010;
  localparam logic [2:0] PH_FIRST = 3'b000;
  localparam logic [2:0] PH_TEXT  = 3'b001;
  localparam logic [2:0] PH_LAST  = 3'b011;
  localparam logic [2:0] PH_ONLY  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_AAD, ST_TEXT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       j0_q, j0_d;
  logic [127:0]       len_q, len_d;
  logic               tag_pending_q, tag_pending_d;

  logic               aad_valid_q, aad_valid_d;
  logic [127:0]       aad_q, aad_d;
  logic               text_valid_q, text_valid_d;
  logic               text_first_q, text_first_d;
  logic               text_last_q, text_last_d;
  logic [127:0]       text_q, text_d;
  logic [127:0]       ctr_block_q, ctr_block_d;
  logic               tag_req_q, tag_req_d;
  logic [127:0]       tag_ctr_q, tag_ctr_d;
  logic [127:0]       len_block_q, len_block_d;
  logic               err_q, err_d;

  logic               is_new;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_inc;
  logic [127:0]       ctr_calc;
  logic               text_ovf;
  logic               is_text;
  logic               legal;
  logic               want_first;
  logic               want_last;
  logic               viol;

  always_comb begin
    is_new   = bus.i_new_instance && (bus.i_phase != PH_INV);
    j0_d     = is_new ? {bus.i_iv, CTR_W'(1)} : j0_q;
    len_d    = is_new ? bus.i_instance_size : len_q;
    cnt_base = is_new ? '0 : cnt_q;
    cnt_inc  = cnt_base + CNT_W'(1);
    // Counter for text block k is J0 with k added mod 2^CTR_W: same as k successive inc32 steps.
    ctr_calc = {j0_d[127:CTR_W], j0_d[CTR_W-1:0] + CTR_W'(cnt_inc)};
    text_ovf = (cnt_inc > CNT_W'(MAX_TEXT_BLOCKS));

    state_d       = state_q;
    cnt_d         = cnt_base;
    tag_pending_d = 1'b0;
    aad_valid_d   = 1'b0;
    aad_d         = aad_q;
    text_valid_d  = 1'b0;
    text_first_d  = 1'b0;
    text_last_d   = 1'b0;
    text_d        = text_q;
    ctr_block_d   = ctr_block_q;
    err_d         = 1'b0;
    tag_req_d     = tag_pending_q;
    is_text       = 1'b0;
    legal         = 1'b0;
    want_first    = 1'b0;
    want_last     = 1'b0;
    viol          = 1'b0;

    case (bus.i_phase)
      PH_INV: begin
      end
      PH_AAD: begin
        if (is_new || state_q != ST_TEXT) begin
          aad_valid_d = 1'b1;
          aad_d       = bus.i_aad;
          state_d     = ST_AAD;
        end else begin
          viol = 1'b1;
        end
      end
      PH_FIRST: begin
        is_text    = 1'b1;
        legal      = is_new || state_q == ST_AAD;
        want_first = 1'b1;
      end
      PH_TEXT: begin
        is_text = 1'b1;
        legal   = !is_new && state_q == ST_TEXT;
      end
      PH_LAST: begin
        is_text   = 1'b1;
        legal     = !is_new && state_q == ST_TEXT;
        want_last = 1'b1;
      end
      PH_ONLY: begin
        is_text    = 1'b1;
        legal      = is_new || state_q == ST_AAD;
        want_first = 1'b1;
        want_last  = 1'b1;
      end
      default: viol = 1'b1;
    endcase

    if (is_text) begin
      if (legal && !text_ovf) begin
        text_valid_d  = 1'b1;
        text_first_d  = want_first;
        text_last_d   = want_last;
        text_d        = bus.i_plain_text;
        ctr_block_d   = ctr_calc;
        cnt_d         = cnt_inc;
        tag_pending_d = want_last;
        state_d       = want_last ? ST_IDLE : ST_TEXT;
      end else begin
        viol = 1'b1;
      end
    end

    if (viol) begin
      err_d         = 1'b1;
      state_d       = ST_IDLE;
      tag_pending_d = 1'b0;
    end

    // While a tag request is about to fire, the tag outputs keep the finished instance's values.
    tag_ctr_d   = tag_pending_q ? tag_ctr_q   : j0_d;
    len_block_d = tag_pending_q ? len_block_q : len_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      j0_q          <= '0;
      len_q         <= '0;
      tag_pending_q <= 1'b0;
      aad_valid_q   <= 1'b0;
      aad_q         <= '0;
      text_valid_q  <= 1'b0;
      text_first_q  <= 1'b0;
      text_last_q   <= 1'b0;
      text_q        <= '0;
      ctr_block_q   <= '0;
      tag_req_q     <= 1'b0;
      tag_ctr_q     <= '0;
      len_block_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      j0_q          <= j0_d;
      len_q         <= len_d;
      tag_pending_q <= tag_pending_d;
      aad_valid_q   <= aad_valid_d;
      aad_q         <= aad_d;
      text_valid_q  <= text_valid_d;
      text_first_q  <= text_first_d;
      text_last_q   <= text_last_d;
      text_q        <= text_d;
      ctr_block_q   <= ctr_block_d;
      tag_req_q     <= tag_req_d;
      tag_ctr_q     <= tag_ctr_d;
      len_block_q   <= len_block_d;
      err_q         <= err_d;
    end
  end

  assign bus.o_aad_valid  = aad_valid_q;
  assign bus.o_aad        = aad_q;
  assign bus.o_text_valid = text_valid_q;
  assign bus.o_text_first = text_first_q;
  assign bus.o_text_last  = text_last_q;
  assign bus.o_text       = text_q;
  assign bus.o_ctr_block  = ctr_block_q;
  assign bus.o_tag_req    = tag_req_q;
  assign bus.o_tag_ctr    = tag_ctr_q;
  assign bus.o_len_block  = len_block_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_aes_gcm_ctr_stage2.sv
// Self-checking bench for aes_gcm_ctr_stage2: vector table plus hand sequences for reset, wrap and overflow.
module tb_aes_gcm_ctr_stage2;

  logic clk;
  logic rst_n;

  aes_gcm_ctr_stage2_if bus();

  aes_gcm_ctr_stage2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [95:0]  IV1 = 96'hCAFEBABEFACEDBADDECAF888;
  localparam logic [95:0]  IV2 = 96'h123456789ABCDEF00F1E2D3C;
  localparam logic [127:0] SZ1 = {64'd128, 64'd384};
  localparam logic [127:0] SZ2 = {64'd0, 64'd128};
  localparam logic [127:0] Z   = 128'd0;

  // expected-flag bits: {aad_valid, text_valid, first, last, err, tag_req}
  localparam logic [5:0] F_AAD = 6'b100000;
  localparam logic [5:0] F_TXT = 6'b010000;
  localparam logic [5:0] F_FST = 6'b001000;
  localparam logic [5:0] F_LST = 6'b000100;
  localparam logic [5:0] F_ERR = 6'b000010;
  localparam logic [5:0] F_TAG = 6'b000001;
  localparam logic [5:0] F_NON = 6'b000000;

  typedef struct {
    logic [2:0]   phase;
    logic         new_inst;
    logic [95:0]  iv;
    logic [127:0] size;
    logic [5:0]   f;
    logic [127:0] e_ctr;
    logic [127:0] e_tag_ctr;
    logic [127:0] e_len;
    logic [127:0] aad_dat;
    logic [127:0] txt_dat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   checks;
  int   failures;

  function automatic vec_t r(input logic [2:0] ph, input logic nw, input logic [95:0] iv,
                             input logic [127:0] sz, input logic [5:0] f, input logic [127:0] ctr,
                             input logic [127:0] tctr, input logic [127:0] len);
    vec_t v;
    v.phase = ph; v.new_inst = nw; v.iv = iv; v.size = sz; v.f = f;
    v.e_ctr = ctr; v.e_tag_ctr = tctr; v.e_len = len;
    v.aad_dat = '0; v.txt_dat = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_out();
    vec_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 128'd1, 128'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("aad_valid",  128'(bus.o_aad_valid),  128'(e.f[5]));
    chk("text_valid", 128'(bus.o_text_valid), 128'(e.f[4]));
    chk("err",        128'(bus.o_err),        128'(e.f[1]));
    chk("tag_req",    128'(bus.o_tag_req),    128'(e.f[0]));
    if (e.f[5]) chk("aad_data", bus.o_aad, e.aad_dat);
    if (e.f[4]) begin
      chk("text_first", 128'(bus.o_text_first), 128'(e.f[3]));
      chk("text_last",  128'(bus.o_text_last),  128'(e.f[2]));
      chk("ctr_block",  bus.o_ctr_block, e.e_ctr);
      chk("text_data",  bus.o_text, e.txt_dat);
    end
    if (e.f[0]) begin
      chk("tag_ctr",   bus.o_tag_ctr,   e.e_tag_ctr);
      chk("len_block", bus.o_len_block, e.e_len);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    e = v;
    e.aad_dat = rnd128();
    e.txt_dat = rnd128();
    bus.i_phase        = v.phase;
    bus.i_new_instance = v.new_inst;
    bus.i_iv           = v.new_inst ? v.iv : rnd128()[95:0];
    bus.i_instance_size = v.new_inst ? v.size : rnd128();
    bus.i_aad          = e.aad_dat;
    bus.i_plain_text   = e.txt_dat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_aad_valid"},  128'(bus.o_aad_valid),  Z);
    chk({tag, "_aad"},        bus.o_aad,              Z);
    chk({tag, "_text_valid"}, 128'(bus.o_text_valid), Z);
    chk({tag, "_first_last"}, 128'({bus.o_text_first, bus.o_text_last}), Z);
    chk({tag, "_text"},       bus.o_text,             Z);
    chk({tag, "_ctr_block"},  bus.o_ctr_block,        Z);
    chk({tag, "_tag_req"},    128'(bus.o_tag_req),    Z);
    chk({tag, "_tag_ctr"},    bus.o_tag_ctr,          Z);
    chk({tag, "_len_block"},  bus.o_len_block,        Z);
    chk({tag, "_err"},        128'(bus.o_err),        Z);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // basic instance, idle violation, single block
    tbl.push_back(r(3'b100, 1'b0, IV1, SZ1, F_NON, Z, Z, Z));
    tbl.push_back(r(3'b010, 1'b1, IV1, SZ1, F_AAD, Z, Z, Z));
    tbl.push_back(r(3'b000, 1'b0, IV1, SZ1, F_TXT | F_FST, {IV1, 32'h00000002}, Z, Z));
    tbl.push_back(r(3'b001, 1'b0, IV1, SZ1, F_TXT, {IV1, 32'h00000003}, Z, Z));
    tbl.push_back(r(3'b011, 1'b0, IV1, SZ1, F_TXT | F_LST, {IV1, 32'h00000004}, Z, Z));
    tbl.push_back(r(3'b100, 1'b0, IV1, SZ1, F_TAG, Z, {IV1, 32'h00000001}, SZ1));
    tbl.push_back(r(3'b001, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    tbl.push_back(r(3'b100, 1'b0, IV1, SZ1, F_NON, Z, Z, Z));
    tbl.push_back(r(3'b111, 1'b1, IV2, SZ2, F_TXT | F_FST | F_LST, {IV2, 32'h00000002}, Z, Z));
    tbl.push_back(r(3'b100, 1'b0, IV2, SZ2, F_TAG, Z, {IV2, 32'h00000001}, SZ2));
    // back-to-back instances: the tag must carry the first instance's J0 and lengths
    tbl.push_back(r(3'b010, 1'b1, IV1, SZ1, F_AAD, Z, Z, Z));
    tbl.push_back(r(3'b000, 1'b0, IV1, SZ1, F_TXT | F_FST, {IV1, 32'h00000002}, Z, Z));
    tbl.push_back(r(3'b011, 1'b0, IV1, SZ1, F_TXT | F_LST, {IV1, 32'h00000003}, Z, Z));
    tbl.push_back(r(3'b010, 1'b1, IV2, SZ2, F_AAD | F_TAG, Z, {IV1, 32'h00000001}, SZ1));
    tbl.push_back(r(3'b000, 1'b0, IV2, SZ2, F_TXT | F_FST, {IV2, 32'h00000002}, Z, Z));
    // more sequencing violations
    tbl.push_back(r(3'b010, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    tbl.push_back(r(3'b011, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    tbl.push_back(r(3'b000, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    tbl.push_back(r(3'b000, 1'b1, IV1, SZ1, F_TXT | F_FST, {IV1, 32'h00000002}, Z, Z));
    tbl.push_back(r(3'b000, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    tbl.push_back(r(3'b111, 1'b1, IV1, SZ2, F_TXT | F_FST | F_LST, {IV1, 32'h00000002}, Z, Z));
    tbl.push_back(r(3'b010, 1'b1, IV2, SZ1, F_AAD | F_TAG, Z, {IV1, 32'h00000001}, SZ2));
    tbl.push_back(r(3'b100, 1'b0, IV2, SZ1, F_NON, Z, Z, Z));

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.i_phase         = 3'($urandom);
      bus.i_new_instance  = 1'($urandom);
      bus.i_iv            = rnd128()[95:0];
      bus.i_aad           = rnd128();
      bus.i_plain_text    = rnd128();
      bus.i_instance_size = rnd128();
      @(posedge clk);
      #1;
      check_all_zero("reset");
    end
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // reset in the middle of an instance drops it without a tag request
    apply(r(3'b000, 1'b1, IV1, SZ1, F_TXT | F_FST, {IV1, 32'h00000002}, Z, Z));
    apply(r(3'b001, 1'b0, IV1, SZ1, F_TXT, {IV1, 32'h00000003}, Z, Z));
    bus.i_phase = 3'b011;
    bus.i_new_instance = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    apply(r(3'b100, 1'b0, IV1, SZ1, F_NON, Z, Z, Z));
    apply(r(3'b000, 1'b1, IV2, SZ2, F_TXT | F_FST, {IV2, 32'h00000002}, Z, Z));
    apply(r(3'b011, 1'b0, IV2, SZ2, F_TXT | F_LST, {IV2, 32'h00000003}, Z, Z));
    apply(r(3'b100, 1'b0, IV2, SZ2, F_TAG, Z, {IV2, 32'h00000001}, SZ2));

    // inc32 wrap: J0's low word is pinned so the next counters land on the wrap point
    apply(r(3'b000, 1'b1, IV2, SZ1, F_TXT | F_FST, {IV2, 32'h00000002}, Z, Z));
    force dut.j0_q = {IV2, 32'hFFFFFFFD};
    apply(r(3'b001, 1'b0, IV2, SZ1, F_TXT, {IV2, 32'hFFFFFFFF}, Z, Z));
    apply(r(3'b001, 1'b0, IV2, SZ1, F_TXT, {IV2, 32'h00000000}, Z, Z));
    release dut.j0_q;
    apply(r(3'b010, 1'b1, IV1, SZ1, F_AAD, Z, Z, Z));
    apply(r(3'b100, 1'b0, IV1, SZ1, F_NON, Z, Z, Z));

    // block overflow: block 781 is accepted, block 782 raises err
    apply(r(3'b000, 1'b1, IV1, SZ1, F_TXT | F_FST, {IV1, 32'h00000002}, Z, Z));
    for (int k = 2; k <= 781; k++)
      apply(r(3'b001, 1'b0, IV1, SZ1, F_TXT, {IV1, 32'(k + 1)}, Z, Z));
    apply(r(3'b001, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));
    apply(r(3'b100, 1'b0, IV1, SZ1, F_NON, Z, Z, Z));
    apply(r(3'b001, 1'b0, IV1, SZ1, F_ERR, Z, Z, Z));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
